// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access / write-back pipeline stage.
// Holds one execute result in the M register, runs a single outstanding
// data-memory transaction for loads/stores (stalling upstream meanwhile),
// and drives the register-file write port with one-cycle WE pulses.
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] ALUout,
    input  logic [31:0] BB,
    input  logic [4:0]  Rw_out,
    input  logic        MW,
    input  logic        MR,
    input  logic        RW,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [4:0]  Rw_in,
    output logic [31:0] Di,
    output logic        WE,
    output logic [15:0] stall_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_alu_q, m_alu_d;
    logic [31:0] m_bb_q, m_bb_d;
    logic [4:0]  m_rd_q, m_rd_d;
    logic        m_mw_q, m_mw_d;
    logic        m_mr_q, m_mr_d;
    logic        m_rw_q, m_rw_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_di_q, wb_di_d;
    logic [15:0] cnt_q, cnt_d;
    logic        stall_s;
    logic        capture_s;

    assign stall_s   = (state_q == WAIT);
    assign capture_s = in_valid && !stall_s;

    assign stall     = stall_s;
    assign Rw_in     = wb_rd_q;
    assign Di        = wb_di_q;
    assign WE        = wb_we_q;
    assign stall_cnt = cnt_q;

    // Memory request outputs: presented only while a transaction is pending.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0000_0000;
        dmem_wdata = 32'h0000_0000;
        if (stall_s) begin
            dmem_req   = 1'b1;
            dmem_we    = m_mw_q;
            dmem_addr  = m_alu_q;
            dmem_wdata = m_bb_q;
        end else begin
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            dmem_addr  = 32'h0000_0000;
            dmem_wdata = 32'h0000_0000;
        end
    end

    // Next-state logic for FSM, M register, write-back register and stall counter.
    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_alu_d   = m_alu_q;
        m_bb_d    = m_bb_q;
        m_rd_d    = m_rd_q;
        m_mw_d    = m_mw_q;
        m_mr_d    = m_mr_q;
        m_rw_d    = m_rw_q;
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_di_d   = wb_di_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (capture_s && (MR || MW)) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The pending op must survive the whole WAIT period; otherwise an
        // uncaptured cycle simply empties the stage.
        if (capture_s) begin
            m_valid_d = 1'b1;
            m_alu_d   = ALUout;
            m_bb_d    = BB;
            m_rd_d    = Rw_out;
            m_mw_d    = MW;
            m_mr_d    = MR;
            m_rw_d    = RW;
        end else if (!stall_s) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        // A store (MW, even with MR) never writes the register file.
        if (!stall_s && m_valid_q && !m_mr_q && !m_mw_q) begin
            wb_rd_d = m_rd_q;
            wb_di_d = m_alu_q;
            wb_we_d = m_rw_q && (m_rd_q != 5'd0);
        end else if (stall_s && dmem_ack && !m_mw_q) begin
            wb_rd_d = m_rd_q;
            wb_di_d = dmem_rdata;
            wb_we_d = m_rw_q && (m_rd_q != 5'd0);
        end else begin
            wb_we_d = 1'b0;
        end

        if (stall_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_alu_q   <= 32'h0000_0000;
            m_bb_q    <= 32'h0000_0000;
            m_rd_q    <= 5'd0;
            m_mw_q    <= 1'b0;
            m_mr_q    <= 1'b0;
            m_rw_q    <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_di_q   <= 32'h0000_0000;
            cnt_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_alu_q   <= m_alu_d;
            m_bb_q    <= m_bb_d;
            m_rd_q    <= m_rd_d;
            m_mw_q    <= m_mw_d;
            m_mr_q    <= m_mr_d;
            m_rw_q    <= m_rw_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_di_q   <= wb_di_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the CPU pipeline, directly downstream of the decode/execute stage. It registers the execute results (ALUout, BB, Rw_out, MW/MR/RW), performs load/store transactions on an external data-memory handshake, and drives the register-file write port (Rw_in, Di, WE) back into decode/execute. While a memory transaction is outstanding it asserts stall to freeze the upstream stage, and it counts stall cycles for performance measurement.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  stage clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents a valid instruction this cycle
- ALUout  in  32  ALU result; load/store byte address for memory ops
- BB  in  32  second operand; store data
- Rw_out  in  5  destination register index
- MW  in  1  memory write (store)
- MR  in  1  memory read (load)
- RW  in  1  register write requested
- stall  out  1  upstream must hold its outputs; input not accepted this cycle
- dmem_req  out  1  data-memory request, held until acknowledged
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req=1
- dmem_addr  out  32  byte address (ALUout, unmodified, no alignment check)
- dmem_wdata  out  32  store data (BB)
- dmem_rdata  in  32  load data, sampled on the edge where dmem_ack=1
- dmem_ack  in  1  transaction complete; ignored when dmem_req=0
- Rw_in  out  5  register-file write index
- Di  out  32  register-file write data
- WE  out  1  register-file write enable, one-cycle pulse per retiring op
- stall_cnt  out  16  number of cycles stall=1 since reset, saturating

## Operation
- M register (valid, ALUout, BB, Rw_out, MW, MR, RW) loads on every edge where in_valid=1 and stall=0; otherwise valid clears unless the stage is in WAIT.
- FSM states: IDLE, WAIT.
  - IDLE -> WAIT on the edge that captures an op with MR=1 or MW=1.
  - WAIT -> IDLE on the edge where dmem_ack=1.
  - No other transitions.
- stall = (state == WAIT); combinational from state only, never from dmem_ack.
- In WAIT: dmem_req=1, dmem_addr=M.ALUout, dmem_wdata=M.BB, dmem_we=M.MW. In IDLE all four are 0.
- MR and MW both set: treated as a store (MW wins); no register write.
- Write-back register loads on every edge:
  - Non-memory op in M, state IDLE: WE=RW, Rw_in=Rw_out, Di=ALUout.
  - Load completing (ack edge): WE=RW, Rw_in=Rw_out, Di=dmem_rdata.
  - Store completing: WE=0.
  - No op retiring: WE=0; Rw_in/Di hold their previous values.
- WE is forced to 0 whenever Rw_in would be 0 (R0 writes are suppressed).
- stall_cnt increments on every edge where stall=1, saturating at 0xFFFF.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, M.valid=0, all M fields 0, stall=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, Rw_in=0, Di=0, WE=0, stall_cnt=0.
- Non-memory op captured at edge k: WE pulses during cycle k+1..k+2 (loaded at edge k+1). Back-to-back ALU ops retire one per cycle with no stall.
- Memory op captured at edge k: dmem_req and stall rise after edge k. With ack sampled at edge k+n (n>=1), write-back loads at edge k+n, stall falls after k+n, and the next op is accepted at edge k+n+1. Minimum occupancy is 2 cycles; stall_cnt increases by n.
- An ALU op preceding a load retires at the same edge the load is captured; no conflict.
- Reset asserted in WAIT: dmem_req drops immediately, the pending op is discarded, and no WE is produced after release. Data memory must tolerate an abandoned request.
- dmem_ack high while in IDLE: no effect.

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs 0. Release -> stall=0, WE=0.
- ALU op: in_valid=1, ALUout=7, Rw_out=3, RW=1 at edge k -> WE=1, Rw_in=3, Di=7 for exactly one cycle after k+1. Next op ALUout=9, Rw_out=4 at k+1 -> WE=1, Rw_in=4, Di=9 after k+2.
- Load: MR=1, RW=1, ALUout=0x10, Rw_out=5; ack on 2nd WAIT cycle with rdata=0xDEADBEEF -> dmem_req=1 and dmem_we=0 at address 0x10 for 2 cycles, stall=1 for 2 cycles, then WE=1, Rw_in=5, Di=0xDEADBEEF; stall_cnt=2.
- Store: MW=1, MR=1, ALUout=0x20, BB=0x55, ack in 1st WAIT cycle -> dmem_we=1, dmem_wdata=0x55, dmem_addr=0x20, stall for 1 cycle, WE never asserted.
- R0: RW=1, Rw_out=0, ALUout=0x1234 -> WE stays 0.
- Reset in WAIT: load issued, ack withheld, reset pulsed low for 1 cycle -> dmem_req=0 immediately, stall_cnt=0, no WE after release, late ack ignored.
